// File: rtl/matrix_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_frame_rx_if
// Description : Byte-in / bundle-out bus for the operand framing stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_frame_rx_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        err_checksum;
    logic        err_timeout;
    logic        err_overrun;
    logic        busy;

    modport slave (
        input  rx_data, rx_valid, frame_ready,
        output frame_data, frame_valid, err_checksum, err_timeout, err_overrun, busy
    );

    modport master (
        output rx_data, rx_valid, frame_ready,
        input  frame_data, frame_valid, err_checksum, err_timeout, err_overrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/matrix_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : matrix_frame_rx
// Description : Sync hunt, 8-byte operand capture, XOR check, valid/ready hold.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_frame_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         PAYLOAD_BYTES  = 8,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  wire               clk,
    input  wire               rst,
    matrix_frame_rx_if.slave  bus
);

    localparam int           c_timer_w      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0]   c_last_byte    = 3'(PAYLOAD_BYTES - 1);
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_count;
    logic [7:0]             r_xor;
    logic [c_timer_w-1:0]   r_timer;
    logic [63:0]            r_frame_data;
    logic                   r_frame_valid;
    logic                   r_err_checksum;
    logic                   r_err_timeout;
    logic                   r_err_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_HUNT;
            r_count        <= 3'd0;
            r_xor          <= 8'd0;
            r_timer        <= '0;
            r_frame_data   <= 64'd0;
            r_frame_valid  <= 1'b0;
            r_err_checksum <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overrun  <= 1'b0;
        end else begin
            r_err_checksum <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overrun  <= 1'b0;

            case (r_state)
                S_HUNT: begin
                    r_timer <= '0;
                    if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                        r_state <= S_PAYLOAD;
                        r_count <= 3'd0;
                        r_xor   <= 8'd0;
                    end
                end

                S_PAYLOAD: begin
                    if (bus.rx_valid) begin
                        r_frame_data[{r_count, 3'b000} +: 8] <= bus.rx_data;
                        r_xor   <= r_xor ^ bus.rx_data;
                        r_count <= r_count + 3'd1;
                        r_timer <= '0;
                        if (r_count == c_last_byte) begin
                            r_state <= S_CHECK;
                        end
                    end else if (r_timer == c_timer_last) begin
                        // This idle cycle is the TIMEOUT_CYCLES-th in a row.
                        r_err_timeout <= 1'b1;
                        r_timer       <= '0;
                        r_state       <= S_HUNT;
                    end else begin
                        r_timer <= r_timer + c_timer_w'(1);
                    end
                end

                S_CHECK: begin
                    if (bus.rx_valid) begin
                        r_timer <= '0;
                        if (bus.rx_data == r_xor) begin
                            r_frame_valid <= 1'b1;
                            r_state       <= S_HOLD;
                        end else begin
                            r_err_checksum <= 1'b1;
                            r_state        <= S_HUNT;
                        end
                    end else if (r_timer == c_timer_last) begin
                        r_err_timeout <= 1'b1;
                        r_timer       <= '0;
                        r_state       <= S_HUNT;
                    end else begin
                        r_timer <= r_timer + c_timer_w'(1);
                    end
                end

                S_HOLD: begin
                    r_timer <= '0;
                    // Bytes here are dropped, never re-interpreted as a sync.
                    if (bus.rx_valid) begin
                        r_err_overrun <= 1'b1;
                    end
                    if (r_frame_valid && bus.frame_ready) begin
                        r_frame_valid <= 1'b0;
                        r_state       <= S_HUNT;
                    end
                end

                default: begin
                    r_state <= S_HUNT;
                end
            endcase
        end
    end

    assign bus.frame_data   = r_frame_data;
    assign bus.frame_valid  = r_frame_valid;
    assign bus.err_checksum = r_err_checksum;
    assign bus.err_timeout  = r_err_timeout;
    assign bus.err_overrun  = r_err_overrun;
    assign bus.busy         = (r_state != S_HUNT);

endmodule
`default_nettype wire

// File: tb/tb_matrix_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_frame_rx
// Description : Randomised and directed frames checked against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_frame_rx;

    localparam int c_timeout = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_frame_rx_if bus ();

    matrix_frame_rx #(
        .SYNC_BYTE      (8'hA5),
        .PAYLOAD_BYTES  (8),
        .TIMEOUT_CYCLES (c_timeout)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit         r;
        bit         v;
        logic [7:0] d;
        bit         rdy;
    } stim_t;

    stim_t sq[$];
    int    n_vec = 0;
    int    n_err = 0;

    // Reference model: a frame is "sync, then 8 data bytes, then their XOR".
    bit          m_in_frame;
    bit          m_held;
    logic [7:0]  m_bytes[$];
    logic [63:0] m_bundle;
    int          m_idle;
    logic [4:0]  exp_status;   // {frame_valid, err_checksum, err_timeout, err_overrun, busy}
    logic [4:0]  dut_status;

    assign dut_status = {bus.frame_valid, bus.err_checksum, bus.err_timeout,
                         bus.err_overrun, bus.busy};

    task automatic model_step(input stim_t s);
        bit cs = 0, to = 0, ov = 0;
        logic [7:0] x;
        if (s.r) begin
            m_in_frame = 0; m_held = 0; m_idle = 0; m_bytes.delete();
        end else if (m_held) begin
            if (s.v) ov = 1;
            if (s.rdy) m_held = 0;
        end else if (!m_in_frame) begin
            if (s.v && s.d == 8'hA5) begin
                m_in_frame = 1; m_idle = 0; m_bytes.delete();
            end
        end else if (s.v) begin
            m_idle = 0;
            if (m_bytes.size() < 8) begin
                m_bytes.push_back(s.d);
            end else begin
                x = 8'h00;
                foreach (m_bytes[i]) x = x ^ m_bytes[i];
                if (x == s.d) begin
                    m_held = 1;
                    m_bundle = 64'd0;
                    foreach (m_bytes[i]) m_bundle[8*i +: 8] = m_bytes[i];
                end else begin
                    cs = 1;
                end
                m_in_frame = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == c_timeout) begin
                to = 1; m_in_frame = 0;
            end
        end
        exp_status = {m_held, cs, to, ov, m_in_frame || m_held};
    endtask

    task automatic tick(input stim_t s);
        @(negedge clk);
        rst = s.r; bus.rx_valid = s.v; bus.rx_data = s.d; bus.frame_ready = s.rdy;
        model_step(s);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit r, input bit v, input logic [7:0] d, input bit rdy);
        stim_t s;
        s.r = r; s.v = v; s.d = d; s.rdy = rdy;
        sq.push_back(s);
    endtask

    task automatic push_idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) push(0, 0, 8'h00, rdy);
    endtask

    task automatic push_frame(input logic [63:0] pl, input logic [7:0] xor_flip, input bit rdy);
        logic [7:0] x = 8'h00;
        push(0, 1, 8'hA5, rdy);
        for (int i = 0; i < 8; i++) begin
            push(0, 1, pl[8*i +: 8], rdy);
            x = x ^ pl[8*i +: 8];
        end
        push(0, 1, x ^ xor_flip, rdy);
    endtask

    task automatic test_reset;
        stim_t s;
        s.r = 1; s.v = 0; s.d = 8'h00; s.rdy = 1;
        tick(s);
        tick(s);
        n_vec++;
        if (dut_status !== 5'b0) begin
            n_err++; $display("FAIL reset_status: got %b expected %b", dut_status, 5'b0);
        end
        n_vec++;
        if (bus.frame_data !== 64'd0) begin
            n_err++; $display("FAIL reset_data: got %h expected %h", bus.frame_data, 64'd0);
        end
    endtask

    task automatic test_good_frame;
        int n_fv = 0;
        sq.delete();
        push_idle(2, 1);
        push_frame(64'h0807060504030201, 8'h00, 1);
        push_idle(3, 1);
        foreach (sq[i]) begin
            tick(sq[i]);
            n_vec++;
            if (dut_status !== exp_status) begin
                n_err++; $display("FAIL good_frame_status step %0d: got %b expected %b", i, dut_status, exp_status);
            end
            if (exp_status[4]) begin
                n_fv++;
                n_vec++;
                if (bus.frame_data !== 64'h0807060504030201) begin
                    n_err++; $display("FAIL good_frame_data: got %h expected %h", bus.frame_data, 64'h0807060504030201);
                end
            end
        end
        n_vec++;
        if (n_fv !== 1) begin
            n_err++; $display("FAIL good_frame_pulses: got %0d expected 1", n_fv);
        end
    endtask

    task automatic test_bad_checksum;
        int n_cs = 0;
        sq.delete();
        push_frame(64'h0807060504030201, 8'h01, 1);
        push_idle(2, 1);
        push_frame(64'h1122334455667788, 8'h00, 1);
        push_idle(2, 1);
        foreach (sq[i]) begin
            tick(sq[i]);
            n_vec++;
            if (dut_status !== exp_status) begin
                n_err++; $display("FAIL bad_checksum_status step %0d: got %b expected %b", i, dut_status, exp_status);
            end
            if (exp_status[4]) begin
                n_vec++;
                if (bus.frame_data !== m_bundle) begin
                    n_err++; $display("FAIL bad_checksum_data: got %h expected %h", bus.frame_data, m_bundle);
                end
            end
            if (bus.err_checksum === 1'b1) n_cs++;
        end
        n_vec++;
        if (n_cs !== 1) begin
            n_err++; $display("FAIL bad_checksum_pulses: got %0d expected 1", n_cs);
        end
    endtask

    task automatic test_junk_sync;
        sq.delete();
        push(0, 1, 8'h00, 1);
        push(0, 1, 8'hFF, 1);
        push_frame(64'h000000000000A5A5, 8'h00, 1);
        push_idle(2, 1);
        foreach (sq[i]) begin
            tick(sq[i]);
            n_vec++;
            if (dut_status !== exp_status) begin
                n_err++; $display("FAIL junk_sync_status step %0d: got %b expected %b", i, dut_status, exp_status);
            end
            if (exp_status[4]) begin
                n_vec++;
                if (bus.frame_data !== 64'h000000000000A5A5) begin
                    n_err++; $display("FAIL junk_sync_data: got %h expected %h", bus.frame_data, 64'h000000000000A5A5);
                end
            end
        end
    endtask

    task automatic test_overrun;
        int n_ov = 0;
        sq.delete();
        push_frame(64'hDEADBEEF01234567, 8'h00, 0);
        push_idle(2, 0);
        push(0, 1, 8'hA5, 0);
        push(0, 1, 8'h3C, 0);
        push(0, 1, 8'hA5, 0);
        push_idle(1, 0);
        push_idle(3, 1);
        foreach (sq[i]) begin
            tick(sq[i]);
            n_vec++;
            if (dut_status !== exp_status) begin
                n_err++; $display("FAIL overrun_status step %0d: got %b expected %b", i, dut_status, exp_status);
            end
            if (exp_status[4]) begin
                n_vec++;
                if (bus.frame_data !== 64'hDEADBEEF01234567) begin
                    n_err++; $display("FAIL overrun_data: got %h expected %h", bus.frame_data, 64'hDEADBEEF01234567);
                end
            end
            if (bus.err_overrun === 1'b1) n_ov++;
        end
        n_vec++;
        if (n_ov !== 3) begin
            n_err++; $display("FAIL overrun_pulses: got %0d expected 3", n_ov);
        end
    endtask

    task automatic test_timeout;
        int n_to = 0;
        sq.delete();
        push(0, 1, 8'hA5, 1);
        push(0, 1, 8'h11, 1); push(0, 1, 8'h22, 1); push(0, 1, 8'h33, 1);
        push_idle(c_timeout, 1);
        push(0, 1, 8'hA5, 1);
        push(0, 1, 8'h11, 1); push(0, 1, 8'h22, 1); push(0, 1, 8'h33, 1);
        push_idle(c_timeout - 1, 1);
        push(0, 1, 8'h44, 1);
        push_idle(c_timeout + 2, 1);
        foreach (sq[i]) begin
            tick(sq[i]);
            n_vec++;
            if (dut_status !== exp_status) begin
                n_err++; $display("FAIL timeout_status step %0d: got %b expected %b", i, dut_status, exp_status);
            end
            if (bus.err_timeout === 1'b1) n_to++;
        end
        n_vec++;
        if (n_to !== 2) begin
            n_err++; $display("FAIL timeout_pulses: got %0d expected 2", n_to);
        end
    endtask

    task automatic test_reset_midframe;
        int n_fv = 0;
        sq.delete();
        push(0, 1, 8'hA5, 1);
        for (int i = 1; i <= 5; i++) push(0, 1, 8'(i), 1);
        push(1, 0, 8'h00, 1);
        push(0, 1, 8'h06, 1); push(0, 1, 8'h07, 1); push(0, 1, 8'h08, 1);
        push(0, 1, 8'h08, 1);
        push_frame(64'h0102030405060708, 8'h00, 1);
        push_idle(2, 1);
        foreach (sq[i]) begin
            tick(sq[i]);
            n_vec++;
            if (dut_status !== exp_status) begin
                n_err++; $display("FAIL reset_mid_status step %0d: got %b expected %b", i, dut_status, exp_status);
            end
            if (sq[i].r) begin
                n_vec++;
                if (bus.frame_data !== 64'd0) begin
                    n_err++; $display("FAIL reset_mid_data: got %h expected %h", bus.frame_data, 64'd0);
                end
            end
            if (exp_status[4]) begin
                n_fv++;
                n_vec++;
                if (bus.frame_data !== 64'h0102030405060708) begin
                    n_err++; $display("FAIL reset_mid_frame: got %h expected %h", bus.frame_data, 64'h0102030405060708);
                end
            end
        end
        n_vec++;
        if (n_fv !== 1) begin
            n_err++; $display("FAIL reset_mid_pulses: got %0d expected 1", n_fv);
        end
    endtask

    task automatic test_random;
        logic [63:0] pl;
        logic [7:0]  flip;
        logic [7:0]  junk;
        logic [7:0]  x;
        sq.delete();
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h5A;
                push(0, 1, junk, $urandom_range(0, 9) < 7);
            end
            pl   = {$urandom, $urandom};
            flip = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            x    = 8'h00;
            push(0, 1, 8'hA5, $urandom_range(0, 9) < 7);
            for (int b = 0; b < 9; b++) begin
                if ($urandom_range(0, 29) == 0) push_idle($urandom_range(c_timeout - 1, c_timeout + 2), 1);
                else push_idle($urandom_range(0, 3), $urandom_range(0, 9) < 7);
                if (b < 8) begin
                    push(0, 1, pl[8*b +: 8], $urandom_range(0, 9) < 7);
                    x = x ^ pl[8*b +: 8];
                end else begin
                    push(0, 1, x ^ flip, $urandom_range(0, 9) < 7);
                end
            end
            push_idle($urandom_range(0, 4), $urandom_range(0, 9) < 7);
        end
        push_idle(c_timeout + 2, 1);
        foreach (sq[i]) begin
            tick(sq[i]);
            n_vec++;
            if (dut_status !== exp_status) begin
                n_err++; $display("FAIL random_status step %0d: got %b expected %b", i, dut_status, exp_status);
            end
            if (exp_status[4]) begin
                n_vec++;
                if (bus.frame_data !== m_bundle) begin
                    n_err++; $display("FAIL random_data step %0d: got %h expected %h", i, bus.frame_data, m_bundle);
                end
            end
        end
    endtask

    initial begin
        bus.rx_valid    = 1'b0;
        bus.rx_data     = 8'h00;
        bus.frame_ready = 1'b1;
        m_in_frame = 0; m_held = 0; m_idle = 0; m_bundle = 64'd0; exp_status = 5'b0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_junk_sync();
        test_overrun();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
